// File: rtl/mem_stats_engine.sv
// mem_stats_engine: buffers a DEPTH-byte frame, scans it for wrapped sum and max, holds result until consumed
module mem_stats_engine #(
    parameter int DEPTH = 14,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic [DW-1:0] in_data_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    output logic [DW-1:0] sum_o,
    output logic [DW:0]   largest_no_o,
    output logic          out_valid_o,
    input  logic          out_ready_i
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    typedef enum logic [1:0] {LOAD, SCAN, DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_idx_q, rd_idx_d;
    logic [DW-1:0] acc_sum_q, acc_sum_d;
    logic [DW-1:0] acc_max_q, acc_max_d;
    logic [DW-1:0] sum_q, sum_d;
    logic [DW-1:0] max_q, max_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic [DW-1:0] cur;
    logic [DW-1:0] sum_nxt;
    logic [DW-1:0] max_nxt;

    assign cur          = mem_q[rd_idx_q];
    assign sum_nxt      = acc_sum_q + cur;
    assign max_nxt      = (cur > acc_max_q) ? cur : acc_max_q;
    assign in_ready_o   = (state_q == LOAD);
    assign sum_o        = sum_q;
    assign largest_no_o = {1'b0, max_q};
    assign out_valid_o  = out_valid_q;

    // Frame buffer write; not reset, a flushed byte is never stored.
    always_ff @(posedge clk) begin
        if (in_ready_o && in_valid_i && !flush_i)
            mem_q[wr_ptr_q] <= in_data_i;
    end

    // Next-state logic; flush overrides every other action in the cycle.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_idx_d    = rd_idx_q;
        acc_sum_d   = acc_sum_q;
        acc_max_d   = acc_max_q;
        sum_d       = sum_q;
        max_d       = max_q;
        out_valid_d = out_valid_q;
        if (flush_i) begin
            state_d     = LOAD;
            wr_ptr_d    = '0;
            rd_idx_d    = '0;
            acc_sum_d   = '0;
            acc_max_d   = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid_i) begin
                        wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
                        if (wr_ptr_q == LAST) begin
                            state_d   = SCAN;
                            rd_idx_d  = '0;
                            acc_sum_d = '0;
                            acc_max_d = '0;
                        end
                    end
                end
                SCAN: begin
                    acc_sum_d = sum_nxt;
                    acc_max_d = max_nxt;
                    rd_idx_d  = (rd_idx_q == LAST) ? '0 : rd_idx_q + PW'(1);
                    if (rd_idx_q == LAST) begin
                        sum_d       = sum_nxt;
                        max_d       = max_nxt;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_d = 1'b0;
                        state_d     = LOAD;
                    end
                end
                default: state_d = LOAD;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD;
            wr_ptr_q    <= '0;
            rd_idx_q    <= '0;
            acc_sum_q   <= '0;
            acc_max_q   <= '0;
            sum_q       <= '0;
            max_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_idx_q    <= rd_idx_d;
            acc_sum_q   <= acc_sum_d;
            acc_max_q   <= acc_max_d;
            sum_q       <= sum_d;
            max_q       <= max_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_mem_stats_engine.sv
// tb_mem_stats_engine: directed self-checking bench for mem_stats_engine
module tb_mem_stats_engine;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] sum;
    logic [8:0] largest_no;
    logic       out_valid;
    logic       out_ready = 1'b0;

    int nvec = 0;
    int nerr = 0;
    logic [7:0] frm [14];

    mem_stats_engine dut (
        .clk(clk),
        .rst(rst),
        .flush_i(flush),
        .in_data_i(in_data),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .sum_o(sum),
        .largest_no_o(largest_no),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame();
        for (int i = 0; i < 14; i++) begin
            in_data  = frm[i];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %0d want 0", out_valid); end
        nvec++; if (sum !== 8'd0) begin nerr++; $display("FAIL reset_sum got %0d want 0", sum); end
        nvec++; if (largest_no !== 9'd0) begin nerr++; $display("FAIL reset_largest got %0d want 0", largest_no); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %0d want 1", in_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_ascending();
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) frm[i] = 8'(i + 1);
        load_frame();
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL asc_in_ready_scan got %0d want 0", in_ready); end
        wait_result(n);
        nvec++; if (n != 14) begin nerr++; $display("FAIL asc_latency got %0d want 14", n); end
        nvec++; if (sum !== 8'd105) begin nerr++; $display("FAIL asc_sum got %0d want 105", sum); end
        nvec++; if (largest_no !== 9'd14) begin nerr++; $display("FAIL asc_largest got %0d want 14", largest_no); end
        tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL asc_out_valid_drop got %0d want 0", out_valid); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL asc_in_ready_back got %0d want 1", in_ready); end
        nvec++; if (sum !== 8'd105) begin nerr++; $display("FAIL asc_sum_hold got %0d want 105", sum); end
    endtask

    task automatic test_all_ff();
        int n;
        for (int i = 0; i < 14; i++) frm[i] = 8'hFF;
        load_frame();
        wait_result(n);
        nvec++; if (n != 14) begin nerr++; $display("FAIL ff_latency got %0d want 14", n); end
        nvec++; if (sum !== 8'd242) begin nerr++; $display("FAIL ff_sum got %0d want 242", sum); end
        nvec++; if (largest_no !== 9'd255) begin nerr++; $display("FAIL ff_largest got %0d want 255", largest_no); end
        tick();
    endtask

    task automatic test_max_first();
        int n;
        frm[0] = 8'd200;
        for (int i = 1; i < 14; i++) frm[i] = 8'd10;
        load_frame();
        wait_result(n);
        nvec++; if (sum !== 8'd74) begin nerr++; $display("FAIL maxfirst_sum got %0d want 74", sum); end
        nvec++; if (largest_no !== 9'd200) begin nerr++; $display("FAIL maxfirst_largest got %0d want 200", largest_no); end
        tick();
    endtask

    task automatic test_stall();
        int n;
        out_ready = 1'b0;
        for (int i = 0; i < 14; i++) frm[i] = 8'd7;
        load_frame();
        wait_result(n);
        nvec++; if (n != 14) begin nerr++; $display("FAIL stall_latency got %0d want 14", n); end
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            in_data  = 8'h55;
            tick();
            nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL stall_out_valid cyc %0d got %0d want 1", c, out_valid); end
            nvec++; if (sum !== 8'd98) begin nerr++; $display("FAIL stall_sum cyc %0d got %0d want 98", c, sum); end
            nvec++; if (largest_no !== 9'd7) begin nerr++; $display("FAIL stall_largest cyc %0d got %0d want 7", c, largest_no); end
            nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL stall_in_ready cyc %0d got %0d want 0", c, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL stall_release got %0d want 0", out_valid); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL stall_in_ready_back got %0d want 1", in_ready); end
    endtask

    task automatic test_flush();
        int n;
        for (int i = 0; i < 6; i++) begin
            in_data  = 8'd99;
            in_valid = 1'b1;
            tick();
        end
        in_data = 8'd200;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL flush_in_ready got %0d want 1", in_ready); end
        nvec++; if (sum !== 8'd98) begin nerr++; $display("FAIL flush_sum_kept got %0d want 98", sum); end
        for (int i = 0; i < 14; i++) frm[i] = 8'(i + 1);
        load_frame();
        wait_result(n);
        nvec++; if (n != 14) begin nerr++; $display("FAIL flush_latency got %0d want 14", n); end
        nvec++; if (sum !== 8'd105) begin nerr++; $display("FAIL flush_sum got %0d want 105", sum); end
        nvec++; if (largest_no !== 9'd14) begin nerr++; $display("FAIL flush_largest got %0d want 14", largest_no); end
        tick();
        load_frame();
        repeat (5) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL flush_scan_in_ready got %0d want 1", in_ready); end
        n = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid) n++;
        end
        nvec++; if (n != 0) begin nerr++; $display("FAIL flush_scan_no_result got %0d valid cycles want 0", n); end
    endtask

    task automatic test_rst_scan();
        int n;
        for (int i = 0; i < 14; i++) frm[i] = 8'(i + 1);
        load_frame();
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid got %0d want 0", out_valid); end
        nvec++; if (sum !== 8'd0) begin nerr++; $display("FAIL rst_sum got %0d want 0", sum); end
        nvec++; if (largest_no !== 9'd0) begin nerr++; $display("FAIL rst_largest got %0d want 0", largest_no); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_in_ready got %0d want 1", in_ready); end
        #1 rst = 1'b0;
        tick();
        for (int i = 0; i < 14; i++) frm[i] = 8'd0;
        load_frame();
        wait_result(n);
        nvec++; if (n != 14) begin nerr++; $display("FAIL zero_latency got %0d want 14", n); end
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL zero_out_valid got %0d want 1", out_valid); end
        nvec++; if (sum !== 8'd0) begin nerr++; $display("FAIL zero_sum got %0d want 0", sum); end
        nvec++; if (largest_no !== 9'd0) begin nerr++; $display("FAIL zero_largest got %0d want 0", largest_no); end
        tick();
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_all_ff();
        test_max_first();
        test_stall();
        test_flush();
        test_rst_scan();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
